// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op classification for the multi-cycle ALU.
// The iterative MUL/MULHU/DIVU/REMU path is enabled by defining ALU_MULDIV_EN.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle for XLEN cycles.
// Only instantiated when ALU_MULDIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [XLEN-1:0]  hi_r;
  logic [XLEN-1:0]  lo_r;
  logic [XLEN-1:0]  b_r;
  logic [3:0]       op_r;
  logic             is_div_s;
  logic [XLEN:0]    sum_s;
  logic [XLEN:0]    rem_sh_s;
  logic [XLEN:0]    trial_s;
  logic [XLEN-1:0]  hi_nx_s;
  logic [XLEN-1:0]  lo_nx_s;

  // hi holds product-high / remainder, lo holds multiplier-low / quotient.
  always_comb begin
    is_div_s = (op_r == OP_DIVU) || (op_r == OP_REMU);
    sum_s    = {1'b0, hi_r} + {1'b0, (lo_r[0] ? b_r : {XLEN{1'b0}})};
    rem_sh_s = {hi_r, lo_r[XLEN-1]};
    trial_s  = rem_sh_s - {1'b0, b_r};
    if (is_div_s) begin
      if (trial_s[XLEN]) begin
        hi_nx_s = rem_sh_s[XLEN-1:0];
        lo_nx_s = {lo_r[XLEN-2:0], 1'b0};
      end else begin
        hi_nx_s = trial_s[XLEN-1:0];
        lo_nx_s = {lo_r[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_nx_s = sum_s[XLEN:1];
      lo_nx_s = {sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Final-step values are presented combinationally so the caller registers them on the last edge.
  always_comb begin
    done = busy_r && (cnt_r == CNT_W'(XLEN - 1));
    case (op_r)
      OP_MUL:   result = lo_nx_s;
      OP_MULHU: result = hi_nx_s;
      OP_DIVU:  result = lo_nx_s;
      OP_REMU:  result = hi_nx_s;
      default:  result = {XLEN{1'b0}};
    endcase
  end

  // Operand load on start, then one iteration per cycle while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      hi_r   <= {XLEN{1'b0}};
      lo_r   <= {XLEN{1'b0}};
      b_r    <= {XLEN{1'b0}};
      op_r   <= 4'b0000;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= {CNT_W{1'b0}};
      hi_r   <= {XLEN{1'b0}};
      lo_r   <= a;
      b_r    <= b;
      op_r   <= op;
    end else if (busy_r) begin
      hi_r   <= hi_nx_s;
      lo_r   <= lo_nx_s;
      cnt_r  <= cnt_r + CNT_W'(1);
      busy_r <= !done;
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops complete in one cycle.
// Defining ALU_MULDIV_EN adds iterative MUL/MULHU/DIVU/REMU; otherwise those codes are illegal.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  state_e             state_r;
  logic               accept_s;
  logic               mc_s;
  logic               iter_done_s;
  logic [XLEN-1:0]    iter_res_s;
  logic [XLEN-1:0]    alu_res_s;
  logic               alu_ill_s;
  logic [SHAMT_W-1:0] shamt_s;

  assign in_ready = rst_n && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign accept_s = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  assign mc_s = is_multicycle(alu_ctrl);

  alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept_s && mc_s),
    .op     (alu_ctrl),
    .a      (a),
    .b      (b),
    .done   (iter_done_s),
    .result (iter_res_s)
  );
`else
  assign mc_s        = 1'b0;
  assign iter_done_s = 1'b0;
  assign iter_res_s  = {XLEN{1'b0}};
`endif

  // Single-cycle datapath; mul/div codes fall to illegal here and are overridden by mc_s.
  always_comb begin
    shamt_s   = b[SHAMT_W-1:0];
    alu_ill_s = 1'b0;
    case (alu_ctrl)
      OP_ADD:  alu_res_s = a + b;
      OP_SUB:  alu_res_s = a - b;
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_SLL:  alu_res_s = a << shamt_s;
      OP_SRL:  alu_res_s = a >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(a) >>> shamt_s);
      OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (a < b)};
      default: begin
        alu_res_s = {XLEN{1'b0}};
        alu_ill_s = 1'b1;
      end
    endcase
  end

  // Control FSM with registered result, illegal and out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      result    <= {XLEN{1'b0}};
      illegal   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            if (mc_s) begin
              state_r   <= EXEC;
              out_valid <= 1'b0;
            end else begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              result    <= alu_res_s;
              illegal   <= alu_ill_s;
            end
          end else if ((state_r == DONE) && !out_ready) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
          end else begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        EXEC: begin
          if (iter_done_s) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            result    <= iter_res_s;
            illegal   <= 1'b0;
          end else begin
            state_r   <= EXEC;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc with a queue scoreboard; honours ALU_MULDIV_EN.
module tb_alu_mc;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      alu_ctrl;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  int errors = 0;
  int checks = 0;
  logic [XLEN:0] exp_q[$];

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            ill;
    int              lat;
  } vec_t;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference model for single-cycle codes; everything else is illegal.
  function automatic logic [XLEN:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] x,
                                           input logic [XLEN-1:0] y);
    logic [4:0] sh;
    sh = y[4:0];
    case (op)
      4'b0000: return {1'b0, x + y};
      4'b0001: return {1'b0, x + ~y + 32'd1};
      4'b0010: return {1'b0, x & y};
      4'b0011: return {1'b0, x | y};
      4'b0100: return {1'b0, x ^ y};
      4'b0101: return {1'b0, x << sh};
      4'b0110: return {1'b0, x >> sh};
      4'b0111: return {1'b0, (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0)};
      4'b1000: return {1'b0, 31'd0, (x[31] != y[31]) ? x[31] : (x < y)};
      4'b1001: return {1'b0, 31'd0, (x < y)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; alu_ctrl = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (result !== 32'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_result: got %h/%b want 0/0", result, illegal);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_ops();
    vec_t v[$];
    int cyc;
    logic [XLEN:0] want;
    v.push_back('{4'b0000, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0, 1});
    v.push_back('{4'b0001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1});
    v.push_back('{4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1});
    v.push_back('{4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1});
    v.push_back('{4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1});
    v.push_back('{4'b0101, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1});
    v.push_back('{4'b0110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1});
    v.push_back('{4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1});
    v.push_back('{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1});
    v.push_back('{4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1});
    v.push_back('{4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1});
    v.push_back('{4'b1001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1});
    foreach (v[i]) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready op=%b: got %b want 1", v[i].op, in_ready); end
      in_valid = 1'b1; out_ready = 1'b1;
      a = v[i].a; b = v[i].b; alu_ctrl = v[i].op;
      exp_q.push_back({v[i].ill, v[i].res});
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 80) begin @(negedge clk); cyc++; end
      checks++;
      if (out_valid !== 1'b1 || cyc != v[i].lat - 1) begin
        errors++; $display("FAIL single_latency op=%b: got %0d want %0d", v[i].op, cyc + 1, v[i].lat);
      end
      want = exp_q.pop_front();
      checks++;
      if ({illegal, result} !== want) begin
        errors++; $display("FAIL single_result op=%b: got %b/%h want %b/%h", v[i].op, illegal, result, want[XLEN], want[XLEN-1:0]);
      end
    end
  endtask

  task automatic test_muldiv();
    vec_t v[$];
    int cyc;
    logic [XLEN:0] want;
`ifdef ALU_MULDIV_EN
    v.push_back('{4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, XLEN + 1});
    v.push_back('{4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, XLEN + 1});
    v.push_back('{4'b1010, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0, XLEN + 1});
    v.push_back('{4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, XLEN + 1});
    v.push_back('{4'b1100, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, XLEN + 1});
    v.push_back('{4'b1101, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, XLEN + 1});
    v.push_back('{4'b1100, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, XLEN + 1});
    v.push_back('{4'b1101, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, XLEN + 1});
    v.push_back('{4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, XLEN + 1});
`else
    v.push_back('{4'b1010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1});
    v.push_back('{4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
    v.push_back('{4'b1100, 32'h0000_0064, 32'h0000_0007, 32'h0000_0000, 1'b1, 1});
    v.push_back('{4'b1101, 32'h0000_0064, 32'h0000_0007, 32'h0000_0000, 1'b1, 1});
`endif
    v.push_back('{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1});
    v.push_back('{4'b1110, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1});
    foreach (v[i]) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      a = v[i].a; b = v[i].b; alu_ctrl = v[i].op;
      exp_q.push_back({v[i].ill, v[i].res});
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 80) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL exec_in_ready op=%b: got %b want 0", v[i].op, in_ready); end
        @(negedge clk); cyc++;
      end
      checks++;
      if (out_valid !== 1'b1 || cyc != v[i].lat - 1) begin
        errors++; $display("FAIL muldiv_latency op=%b: got %0d want %0d", v[i].op, cyc + 1, v[i].lat);
      end
      want = exp_q.pop_front();
      checks++;
      if ({illegal, result} !== want) begin
        errors++; $display("FAIL muldiv_result op=%b: got %b/%h want %b/%h", v[i].op, illegal, result, want[XLEN], want[XLEN-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[4];
    logic [XLEN:0] want;
    logic [XLEN:0] held;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0111; ops[3] = 4'b1000;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    a = $urandom; b = $urandom; alu_ctrl = ops[0];
    exp_q.push_back(ref_alu(alu_ctrl, a, b));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat=%0d: got %b want 1", i, out_valid); end
      want = exp_q.pop_front();
      checks++;
      if ({illegal, result} !== want) begin
        errors++; $display("FAIL b2b_result beat=%0d: got %b/%h want %b/%h", i, illegal, result, want[XLEN], want[XLEN-1:0]);
      end
      if (i < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat=%0d: got %b want 1", i, in_ready); end
        a = $urandom; b = $urandom; alu_ctrl = ops[i];
        exp_q.push_back(ref_alu(alu_ctrl, a, b));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    in_valid = 1'b1; out_ready = 1'b0;
    a = $urandom; b = $urandom; alu_ctrl = 4'b0100;
    exp_q.push_back(ref_alu(alu_ctrl, a, b));
    @(negedge clk);
    a = ~a; alu_ctrl = 4'b0001;
    held = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_flags cycle=%0d: got valid=%b ready=%b want 1/0", k, out_valid, in_ready);
      end
      checks++;
      if ({illegal, result} !== held) begin
        errors++; $display("FAIL stall_hold cycle=%0d: got %h want %h", k, result, held[XLEN-1:0]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
`ifdef ALU_MULDIV_EN
    out_ready = 1'b1; a = 32'd100; b = 32'd7; alu_ctrl = 4'b1100;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (XLEN / 2 - 1) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midexec_valid: got %b want 0", out_valid); end
`else
    out_ready = 1'b0; a = 32'd100; b = 32'd7; alu_ctrl = 4'b0000;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL middone_valid: got %b want 1", out_valid); end
`endif
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got %b/%h/%b want 0/0/0", out_valid, result, illegal);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    seen = 0;
    repeat (XLEN + 8) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_stale: got %0d outputs want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
